// File: rtl/signed_narrower_sat_if.sv
// Stream, status and counter-control signals of signed_narrower_sat, grouped as one bundle.
interface signed_narrower_sat_if #(
  parameter int INPUT_WIDTH  = 9,
  parameter int OUTPUT_WIDTH = 8,
  parameter int CNT_WIDTH    = 8
);
  logic                           In_Valid;
  logic                           In_Ready;
  logic signed [INPUT_WIDTH-1:0]  Data_In;
  logic                           Out_Valid;
  logic                           Out_Ready;
  logic signed [OUTPUT_WIDTH-1:0] Data_Out;
  logic                           Sat_Flag;
  logic [CNT_WIDTH-1:0]           Sat_Count;
  logic                           Clear_Count;

  modport master (
    output In_Valid, Data_In, Out_Ready, Clear_Count,
    input  In_Ready, Out_Valid, Data_Out, Sat_Flag, Sat_Count
  );

  modport slave (
    input  In_Valid, Data_In, Out_Ready, Clear_Count,
    output In_Ready, Out_Valid, Data_Out, Sat_Flag, Sat_Count
  );
endinterface

// File: rtl/signed_narrower_sat.sv
// Two-stage signed narrower: optional arithmetic rescale, then clamp into OUTPUT_WIDTH bits.
// Define SIGNED_NARROWER_ROUND_EN for round-half-up before the shift (default: floor).
module signed_narrower_sat #(
  parameter int INPUT_WIDTH  = 9,
  parameter int OUTPUT_WIDTH = 8,
  parameter int SHIFT        = 0,
  parameter int CNT_WIDTH    = 8
) (
  input logic                  Clk,
  input logic                  Reset,
  signed_narrower_sat_if.slave bus
);

  localparam int W = INPUT_WIDTH + 1;

  localparam logic signed [W-1:0] SAT_MAX =
    {{(W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN =
    {{(W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

`ifdef SIGNED_NARROWER_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W-1:0] RND = (SHIFT > 0) ? (W'(1) << RND_POS) : '0;
`endif

  logic                    adv;
  logic signed [W-1:0]     ext;
  logic signed [W-1:0]     pre_shift;
  logic signed [W-1:0]     shifted;
  logic                    s1_valid;
  logic signed [W-1:0]     s1_data;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    out_valid;
  logic [OUTPUT_WIDTH-1:0] data_out;
  logic                    sat_flag;
  logic [CNT_WIDTH-1:0]    sat_count;

  // Both stages move together; a stalled output freezes stage 1 as well.
  assign adv          = !out_valid || bus.Out_Ready;
  assign bus.In_Ready = adv;

  // The extra guard bit keeps the rounding add from overflowing.
  always_comb begin
    ext = {bus.Data_In[INPUT_WIDTH-1], bus.Data_In};
`ifdef SIGNED_NARROWER_ROUND_EN
    pre_shift = ext + RND;
`else
    pre_shift = ext;
`endif
    shifted = pre_shift >>> SHIFT;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= bus.In_Valid;
      s1_data  <= shifted;
    end
  end

  always_comb begin
    sat_hi = s1_data > SAT_MAX;
    sat_lo = s1_data < SAT_MIN;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (sat_hi) begin
        data_out <= OUT_MAX;
        sat_flag <= 1'b1;
      end else if (sat_lo) begin
        data_out <= OUT_MIN;
        sat_flag <= 1'b1;
      end else begin
        data_out <= s1_data[OUTPUT_WIDTH-1:0];
        sat_flag <= 1'b0;
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sat_count <= '0;
    end else if (bus.Clear_Count) begin
      sat_count <= '0;
    end else if (out_valid && bus.Out_Ready && sat_flag && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign bus.Out_Valid = out_valid;
  assign bus.Data_Out  = data_out;
  assign bus.Sat_Flag  = sat_flag;
  assign bus.Sat_Count = sat_count;

endmodule

// File: tb/tb_signed_narrower_sat.sv
// Bench for signed_narrower_sat: directed scenarios on three configurations plus a
// randomized scoreboard against an integer-arithmetic reference model.
module tb_signed_narrower_sat;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: default widths; b: 2-bit counter; c: SHIFT=2 into 6 bits
  signed_narrower_sat_if #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(8), .CNT_WIDTH(8)) a_if ();
  signed_narrower_sat_if #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(8), .CNT_WIDTH(2)) b_if ();
  signed_narrower_sat_if #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(6), .CNT_WIDTH(8)) c_if ();

  signed_narrower_sat #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(8), .SHIFT(0), .CNT_WIDTH(8)) dut_a (
    .Clk(clk), .Reset(rst), .bus(a_if.slave));
  signed_narrower_sat #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(8), .SHIFT(0), .CNT_WIDTH(2)) dut_b (
    .Clk(clk), .Reset(rst), .bus(b_if.slave));
  signed_narrower_sat #(.INPUT_WIDTH(9), .OUTPUT_WIDTH(6), .SHIFT(2), .CNT_WIDTH(8)) dut_c (
    .Clk(clk), .Reset(rst), .bus(c_if.slave));

  // Reference: divide by 2^shift rounding toward -inf (optionally after adding half), then clamp.
  function automatic int model(input int v, input int shift, input int outw, output bit sat);
    int d, r, q, hi, lo;
    d = 1 << shift;
    r = v;
`ifdef SIGNED_NARROWER_ROUND_EN
    if (shift > 0) r = v + d / 2;
`endif
    q = r / d;
    if ((r % d) != 0 && r < 0) q = q - 1;
    hi = (1 << (outw - 1)) - 1;
    lo = -(1 << (outw - 1));
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    return q;
  endfunction

  task automatic idle_all();
    a_if.In_Valid = 0; a_if.Data_In = '0; a_if.Out_Ready = 0; a_if.Clear_Count = 0;
    b_if.In_Valid = 0; b_if.Data_In = '0; b_if.Out_Ready = 0; b_if.Clear_Count = 0;
    c_if.In_Valid = 0; c_if.Data_In = '0; c_if.Out_Ready = 0; c_if.Clear_Count = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_all();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (a_if.Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_if.Out_Valid); end
    checks++; if (a_if.Data_Out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", a_if.Data_Out); end
    checks++; if (a_if.Sat_Flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", a_if.Sat_Flag); end
    checks++; if (a_if.Sat_Count !== 8'h00) begin errors++; $display("FAIL reset_sat_count: got %h expected 00", a_if.Sat_Count); end
    checks++; if (b_if.Sat_Count !== 2'b00) begin errors++; $display("FAIL reset_sat_count_b: got %b expected 00", b_if.Sat_Count); end
    checks++; if (c_if.Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_c: got %b expected 0", c_if.Out_Valid); end
    rst = 0;
    @(negedge clk);
    checks++; if (a_if.In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_if.In_Ready); end
  endtask

  task automatic test_passthrough();
    @(negedge clk); a_if.Out_Ready = 1; a_if.In_Valid = 1; a_if.Data_In = 9'h07F;
    @(negedge clk); a_if.Data_In = 9'h180;
    checks++; if (a_if.Out_Valid !== 1'b0) begin errors++; $display("FAIL pass_latency: out_valid got %b expected 0", a_if.Out_Valid); end
    @(negedge clk); a_if.In_Valid = 0;
    checks++; if (a_if.Out_Valid !== 1'b1 || a_if.Data_Out !== 8'h7F || a_if.Sat_Flag !== 1'b0)
      begin errors++; $display("FAIL pass_max: got v=%b d=%h f=%b expected v=1 d=7f f=0", a_if.Out_Valid, a_if.Data_Out, a_if.Sat_Flag); end
    @(negedge clk);
    checks++; if (a_if.Out_Valid !== 1'b1 || a_if.Data_Out !== 8'h80 || a_if.Sat_Flag !== 1'b0)
      begin errors++; $display("FAIL pass_min: got v=%b d=%h f=%b expected v=1 d=80 f=0", a_if.Out_Valid, a_if.Data_Out, a_if.Sat_Flag); end
    @(negedge clk);
    checks++; if (a_if.Out_Valid !== 1'b0) begin errors++; $display("FAIL pass_drain: out_valid got %b expected 0", a_if.Out_Valid); end
    checks++; if (a_if.Sat_Count !== 8'd0) begin errors++; $display("FAIL pass_count: got %0d expected 0", a_if.Sat_Count); end
  endtask

  task automatic test_saturate();
    @(negedge clk); a_if.Out_Ready = 1; a_if.In_Valid = 1; a_if.Data_In = 9'h0FF;
    @(negedge clk); a_if.Data_In = 9'h100;
    @(negedge clk); a_if.In_Valid = 0;
    checks++; if (a_if.Out_Valid !== 1'b1 || a_if.Data_Out !== 8'h7F || a_if.Sat_Flag !== 1'b1)
      begin errors++; $display("FAIL sat_hi: got v=%b d=%h f=%b expected v=1 d=7f f=1", a_if.Out_Valid, a_if.Data_Out, a_if.Sat_Flag); end
    @(negedge clk);
    checks++; if (a_if.Out_Valid !== 1'b1 || a_if.Data_Out !== 8'h80 || a_if.Sat_Flag !== 1'b1)
      begin errors++; $display("FAIL sat_lo: got v=%b d=%h f=%b expected v=1 d=80 f=1", a_if.Out_Valid, a_if.Data_Out, a_if.Sat_Flag); end
    checks++; if (a_if.Sat_Count !== 8'd1) begin errors++; $display("FAIL sat_count1: got %0d expected 1", a_if.Sat_Count); end
    @(negedge clk);
    checks++; if (a_if.Sat_Count !== 8'd2) begin errors++; $display("FAIL sat_count2: got %0d expected 2", a_if.Sat_Count); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int stall_left = 0;
    bit stalled = 0;
    int got[$];
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      @(negedge clk);
      if (a_if.Out_Valid && !stalled) begin stalled = 1; stall_left = 3; end
      a_if.Out_Ready = (stall_left == 0);
      a_if.In_Valid  = (sent < 4);
      a_if.Data_In   = 9'(sent + 1);
      #1;
      if (stall_left > 0) begin
        checks++; if (a_if.Data_Out !== 8'd1) begin errors++; $display("FAIL stall_hold: data got %0d expected 1", a_if.Data_Out); end
        checks++; if (a_if.In_Ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", a_if.In_Ready); end
        stall_left--;
      end
      if (a_if.In_Valid && a_if.In_Ready) sent++;
      if (a_if.Out_Valid && a_if.Out_Ready) got.push_back(int'(a_if.Data_Out));
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      a_if.In_Valid = 0; a_if.Out_Ready = 1;
      #1;
      if (a_if.Out_Valid && a_if.Out_Ready) got.push_back(int'(a_if.Data_Out));
    end
    checks++; if (!stalled) begin errors++; $display("FAIL stall_timeout: out_valid never rose"); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_beats: got %0d beats expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] != i + 1) begin errors++; $display("FAIL stall_order[%0d]: got %0d expected %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_count_sticky();
    bit seen = 0;
    @(negedge clk); b_if.Out_Ready = 1; b_if.In_Valid = 1; b_if.Data_In = 9'h0FF;
    repeat (5) @(negedge clk);
    b_if.In_Valid = 0;
    repeat (4) @(negedge clk);
    checks++; if (b_if.Sat_Count !== 2'd3) begin errors++; $display("FAIL count_sticky: got %0d expected 3", b_if.Sat_Count); end
    b_if.In_Valid = 1;
    @(negedge clk); b_if.In_Valid = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (b_if.Out_Valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL count_clear_timeout: out_valid never rose"); end
    else begin
      checks++; if (b_if.Sat_Flag !== 1'b1) begin errors++; $display("FAIL count_clear_flag: got %b expected 1", b_if.Sat_Flag); end
      b_if.Clear_Count = 1;
      @(negedge clk);
      b_if.Clear_Count = 0;
      checks++; if (b_if.Sat_Count !== 2'd0) begin errors++; $display("FAIL count_clear_priority: got %0d expected 0", b_if.Sat_Count); end
    end
    b_if.In_Valid = 1; b_if.Data_In = 9'h100;
    @(negedge clk); b_if.In_Valid = 0;
    repeat (4) @(negedge clk);
    checks++; if (b_if.Sat_Count !== 2'd1) begin errors++; $display("FAIL count_after_clear: got %0d expected 1", b_if.Sat_Count); end
  endtask

  task automatic test_shift_round();
    int vals[3];
    int got_d[$];
    bit got_f[$];
    int exp_d[3];
    bit exp_f[3];
    vals[0] = 6; vals[1] = -6; vals[2] = 255;
`ifdef SIGNED_NARROWER_ROUND_EN
    exp_d[0] = 2; exp_d[1] = -1; exp_d[2] = 31;
`else
    exp_d[0] = 1; exp_d[1] = -2; exp_d[2] = 31;
`endif
    exp_f[0] = 0; exp_f[1] = 0; exp_f[2] = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      c_if.Out_Ready = 1;
      c_if.In_Valid  = (cyc < 3);
      c_if.Data_In   = (cyc < 3) ? 9'(vals[cyc]) : '0;
      #1;
      if (c_if.Out_Valid && c_if.Out_Ready) begin
        got_d.push_back(int'(c_if.Data_Out));
        got_f.push_back(c_if.Sat_Flag);
      end
    end
    c_if.In_Valid = 0;
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL shift_beats: got %0d expected 3", got_d.size()); end
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] != exp_d[i]) begin errors++; $display("FAIL shift_data[%0d]: got %0d expected %0d", i, got_d[i], exp_d[i]); end
      checks++; if (got_f[i] != exp_f[i]) begin errors++; $display("FAIL shift_flag[%0d]: got %0d expected %0d", i, got_f[i], exp_f[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); a_if.Out_Ready = 1; a_if.In_Valid = 1; a_if.Data_In = 9'h0FF;
    @(negedge clk);
    @(negedge clk); a_if.In_Valid = 0; rst = 1;
    @(negedge clk); rst = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      checks++; if (a_if.Out_Valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid[%0d]: got %b expected 0", cyc, a_if.Out_Valid); end
    end
    checks++; if (a_if.Sat_Count !== 8'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", a_if.Sat_Count); end
  endtask

  task automatic test_random();
    int qa_v[$], qc_v[$];
    bit qa_f[$], qc_f[$];
    int cnt_a = 0, cnt_c = 0;
    int v, ev;
    bit f, ef, inc_a, inc_c, drain;
    @(negedge clk); idle_all(); rst = 1;
    @(negedge clk); rst = 0;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      checks++; if (a_if.Sat_Count !== 8'(cnt_a)) begin errors++; $display("FAIL rand_count_a[%0d]: got %0d expected %0d", it, a_if.Sat_Count, cnt_a); end
      checks++; if (c_if.Sat_Count !== 8'(cnt_c)) begin errors++; $display("FAIL rand_count_c[%0d]: got %0d expected %0d", it, c_if.Sat_Count, cnt_c); end
      drain = (it >= 390);
      a_if.In_Valid    = !drain && ($urandom_range(0, 3) != 0);
      a_if.Data_In     = 9'($urandom);
      a_if.Out_Ready   = drain || ($urandom_range(0, 3) != 0);
      a_if.Clear_Count = !drain && ($urandom_range(0, 19) == 0);
      c_if.In_Valid    = !drain && ($urandom_range(0, 3) != 0);
      c_if.Data_In     = 9'($urandom);
      c_if.Out_Ready   = drain || ($urandom_range(0, 2) != 0);
      c_if.Clear_Count = !drain && ($urandom_range(0, 19) == 0);
      #1;
      inc_a = 0; inc_c = 0;
      if (a_if.In_Valid && a_if.In_Ready) begin
        v = model(int'(a_if.Data_In), 0, 8, f); qa_v.push_back(v); qa_f.push_back(f);
      end
      if (c_if.In_Valid && c_if.In_Ready) begin
        v = model(int'(c_if.Data_In), 2, 6, f); qc_v.push_back(v); qc_f.push_back(f);
      end
      if (a_if.Out_Valid && a_if.Out_Ready) begin
        checks++;
        if (qa_v.size() == 0) begin errors++; $display("FAIL rand_extra_a[%0d]: got beat %0d expected none", it, a_if.Data_Out); end
        else begin
          ev = qa_v.pop_front(); ef = qa_f.pop_front();
          checks++; if (int'(a_if.Data_Out) != ev) begin errors++; $display("FAIL rand_data_a[%0d]: got %0d expected %0d", it, int'(a_if.Data_Out), ev); end
          checks++; if (a_if.Sat_Flag !== ef) begin errors++; $display("FAIL rand_flag_a[%0d]: got %b expected %b", it, a_if.Sat_Flag, ef); end
          inc_a = ef && (cnt_a < 255);
        end
      end
      if (c_if.Out_Valid && c_if.Out_Ready) begin
        checks++;
        if (qc_v.size() == 0) begin errors++; $display("FAIL rand_extra_c[%0d]: got beat %0d expected none", it, c_if.Data_Out); end
        else begin
          ev = qc_v.pop_front(); ef = qc_f.pop_front();
          checks++; if (int'(c_if.Data_Out) != ev) begin errors++; $display("FAIL rand_data_c[%0d]: got %0d expected %0d", it, int'(c_if.Data_Out), ev); end
          checks++; if (c_if.Sat_Flag !== ef) begin errors++; $display("FAIL rand_flag_c[%0d]: got %b expected %b", it, c_if.Sat_Flag, ef); end
          inc_c = ef && (cnt_c < 255);
        end
      end
      if (a_if.Clear_Count) cnt_a = 0; else if (inc_a) cnt_a++;
      if (c_if.Clear_Count) cnt_c = 0; else if (inc_c) cnt_c++;
    end
    checks++; if (qa_v.size() != 0) begin errors++; $display("FAIL rand_lost_a: got %0d pending expected 0", qa_v.size()); end
    checks++; if (qc_v.size() != 0) begin errors++; $display("FAIL rand_lost_c: got %0d pending expected 0", qc_v.size()); end
    @(negedge clk); idle_all();
  endtask

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_passthrough();
    test_saturate();
    test_stall();
    test_count_sticky();
    test_shift_round();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signed_narrower_sat.md
Name: signed_narrower_sat

Overview:
Streaming signed width reducer: the inverse direction of the codebase's sign extension path. Takes a wide signed fixed-point value (e.g. accumulated velocity/density terms in the LBM datapath), optionally rescales by an arithmetic right shift, and saturates it into a narrower signed field for storage or transmission. It is a 2-stage pipeline with valid/ready handshake, a per-beat saturation flag and a sticky saturation event counter.

Parameters:
INPUT_WIDTH, 9, width of signed Data_In.
OUTPUT_WIDTH, 8, width of signed Data_Out. Legal range: 2 <= OUTPUT_WIDTH <= INPUT_WIDTH-SHIFT.
SHIFT, 0, arithmetic right shift (fixed-point rescale) applied before saturation. Legal range: 0 <= SHIFT < INPUT_WIDTH.
CNT_WIDTH, 8, width of Sat_Count.

Ports:
Clk  input  1  clock; all logic is rising-edge.
Reset  input  1  synchronous, active-high reset.
In_Valid  input  1  Data_In carries a beat.
In_Ready  output  1  block accepts a beat this cycle.
Data_In  input  INPUT_WIDTH  signed input value.
Out_Valid  output  1  Data_Out carries a beat.
Out_Ready  input  1  downstream accepts the beat.
Data_Out  output  OUTPUT_WIDTH  signed saturated result.
Sat_Flag  output  1  current Data_Out beat was clamped.
Sat_Count  output  CNT_WIDTH  number of clamped beats delivered; sticky at all-ones.
Clear_Count  input  1  synchronous clear of Sat_Count.

Behaviour:
- Single clock (Clk). Reset is synchronous and active-high (Reset).
- Reset: Out_Valid=0, Data_Out=0, Sat_Flag=0, Sat_Count=0, internal stage-1 valid=0. In_Ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded with no output. Sat_Count returns to 0.
- Advance enable: adv = !Out_Valid || Out_Ready. In_Ready = adv, which is combinational from Out_Valid and Out_Ready.
- Both stages advance together only when adv=1. Bubbles are not collapsed.
- Input handshake: In_Valid && In_Ready.
- Output handshake: Out_Valid && Out_Ready.
- Stage 1, when adv=1:
  - s1_valid <= In_Valid.
  - s1_data <= Data_In >>> SHIFT (arithmetic shift). Intermediate width is INPUT_WIDTH+1 to hold rounding carry.
  - When In_Valid=0, s1_data is don't-care.
- Stage 2, when adv=1:
  - Out_Valid <= s1_valid.
  - If s1_data > 2^(OUTPUT_WIDTH-1)-1: Data_Out <= max positive, Sat_Flag <= 1.
  - Else if s1_data < -2^(OUTPUT_WIDTH-1): Data_Out <= min negative, Sat_Flag <= 1.
  - Else: Data_Out <= low OUTPUT_WIDTH bits, Sat_Flag <= 0.
- Latency: 2 cycles from input handshake to Out_Valid when Out_Ready is held high. Throughput is 1 beat/cycle.
- Stall: while Out_Valid=1 and Out_Ready=0, Data_Out, Sat_Flag and the stage-1 contents hold. In_Ready=0. No beat is lost or duplicated, and order is preserved.
- Sat_Count:
  - Increments by 1 on each output handshake with Sat_Flag=1.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Clear_Count=1 sets it to 0. Clear has priority over a coincident increment, so the result is 0.
- Out_Valid=0 beats never affect Sat_Count.

Optional Feature:
Macro SIGNED_NARROWER_ROUND_EN.
- Defined: before the shift, add 2^(SHIFT-1) to the sign-extended INPUT_WIDTH+1 value. This gives round-half-up (toward +inf on ties). Saturation applies after rounding, so rounding can itself cause a clamp.
- Undefined: plain arithmetic shift (floor).
- When SHIFT=0 the macro has no effect in either case.
- Latency, handshake and port list are identical either way.

Test Plan:
1. Defaults; assert Reset 2 cycles -> Out_Valid=0, Data_Out=0, Sat_Flag=0, Sat_Count=0; In_Ready=1 after release.
2. Out_Ready=1; Data_In=127 then -128 -> Data_Out=8'h7F then 8'h80, each 2 cycles after accept, Sat_Flag=0, Sat_Count=0.
3. Data_In=255 then 9'h100 (-256) -> Data_Out=8'h7F with Sat_Flag=1, then 8'h80 with Sat_Flag=1; Sat_Count=2.
4. Stream 1,2,3,4 back-to-back; drop Out_Ready for 3 cycles once Out_Valid rises -> Data_Out holds 1, In_Ready=0 during the stall, then 1,2,3,4 delivered in order exactly once.
5. CNT_WIDTH=2; 5 saturating beats -> Sat_Count=3. Then Clear_Count coincident with a saturating output handshake -> Sat_Count=0.
6. SHIFT=2, INPUT_WIDTH=9, OUTPUT_WIDTH=6:
   - Data_In=6 -> Data_Out=2 with macro, 1 without.
   - Data_In=-6 -> -1 with macro, -2 without.
   - Data_In=255 -> 31, Sat_Flag=1 in both builds.
